ascon_permutation_engine: RTL and testbench

Iterative ASCON permutation p^a / p^b for the cipher datapath. It applies constant addition, the S-box layer and linear diffusion, UNROLL rounds per clock, for a runtime-selected round count of 6, 8 or 12. It uses a start/ready/valid handshake and sits between the mode FSM (init, associated data, plaintext, finalisation) and the 320-bit state register.

---
 rtl/ascon_pack.sv | 30 +++
 rtl/ascon_round.sv | 28 ++
 rtl/ascon_sbox.sv | 38 +++
 rtl/diffusion_lin.sv | 16 +
 rtl/ascon_permutation_engine.sv | 104 ++++++++++
 tb/tb_ascon_permutation_engine.sv | 374 +++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/ascon_pack.sv
// Shared types and helpers for the ASCON permutation datapath.
// The state word is held as five 64-bit lanes, lane i being x<i>.
package ascon_pack;

  typedef logic [4:0][63:0] type_state;

  // Engine FSM encoding.
  typedef logic [1:0] type_fsm;
  localparam type_fsm FSM_IDLE = 2'd0;
  localparam type_fsm FSM_BUSY = 2'd1;
  localparam type_fsm FSM_DONE = 2'd2;

  localparam logic [3:0] N_ROUNDS_P12 = 4'd12;
  localparam logic [3:0] N_ROUNDS_P8  = 4'd8;
  localparam logic [3:0] N_ROUNDS_P6  = 4'd6;

  // Round constant for absolute round index r (0 = first round of p12).
  function automatic logic [7:0] rc(input logic [3:0] r);
    return 8'hF0 - ({4'h0, r} * 8'h0F);
  endfunction

  function automatic logic rounds_legal(input logic [3:0] n);
    return (n == N_ROUNDS_P12) || (n == N_ROUNDS_P8) || (n == N_ROUNDS_P6);
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant addition, substitution, diffusion.
module ascon_round
  import ascon_pack::*;
(
  input  logic [3:0] round_idx,
  input  type_state  x,
  output type_state  y
);

  type_state with_rc;
  type_state after_sbox;

  always_comb begin
    with_rc    = x;
    with_rc[2] = x[2] ^ {56'h0, rc(round_idx)};
  end

  ascon_sbox u_sbox (
    .x (with_rc),
    .y (after_sbox)
  );

  diffusion_lin u_lin (
    .x (after_sbox),
    .y (y)
  );

endmodule

// File: rtl/ascon_sbox.sv
// Bit-sliced 5-bit ASCON S-box applied to all 64 columns of the state.
module ascon_sbox
  import ascon_pack::*;
(
  input  type_state x,
  output type_state y
);

  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] t0, t1, t2, t3, t4;
  logic [63:0] b0, b1, b2, b3, b4;

  assign a0 = x[0] ^ x[4];
  assign a1 = x[1];
  assign a2 = x[2] ^ x[1];
  assign a3 = x[3];
  assign a4 = x[4] ^ x[3];

  // Chi-like nonlinear core.
  assign t0 = ~a0 & a1;
  assign t1 = ~a1 & a2;
  assign t2 = ~a2 & a3;
  assign t3 = ~a3 & a4;
  assign t4 = ~a4 & a0;

  assign b0 = a0 ^ t1;
  assign b1 = a1 ^ t2;
  assign b2 = a2 ^ t3;
  assign b3 = a3 ^ t4;
  assign b4 = a4 ^ t0;

  assign y[0] = b0 ^ b4;
  assign y[1] = b1 ^ b0;
  assign y[2] = ~b2;
  assign y[3] = b3 ^ b2;
  assign y[4] = b4;

endmodule

// File: rtl/diffusion_lin.sv
// ASCON linear diffusion layer: each lane XORed with two rotations of itself.
module diffusion_lin
  import ascon_pack::*;
(
  input  type_state x,
  output type_state y
);

  localparam int unsigned ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int unsigned ROT_B [5] = '{28, 39, 6, 17, 41};

  for (genvar gi = 0; gi < 5; gi++) begin : g_lane
    assign y[gi] = x[gi] ^ ror64(x[gi], ROT_A[gi]) ^ ror64(x[gi], ROT_B[gi]);
  end

endmodule

// File: rtl/ascon_permutation_engine.sv
// Iterative ASCON p^a/p^b engine, UNROLL rounds per clock, start/ready/valid handshake.
// Round indices are absolute (ROUND_MAX-N .. ROUND_MAX-1) so p6/p8 reuse the tail of p12's constants.
module ascon_permutation_engine
  import ascon_pack::*;
#(
  parameter int UNROLL    = 1,
  parameter int ROUND_MAX = 12
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [3:0] nb_rounds_i,
  input  logic       abort_i,
  input  type_state  state_i,
  output type_state  state_o,
  output logic       ready_o,
  output logic       valid_o,
  output logic       err_o
);

  if (!(UNROLL == 1 || UNROLL == 2)) begin : g_bad_unroll
    $error("ascon_permutation_engine: UNROLL must be 1 or 2");
  end
  if (ROUND_MAX < 1 || ROUND_MAX > 15) begin : g_bad_round_max
    $error("ascon_permutation_engine: ROUND_MAX must fit the 4-bit round counter");
  end

  localparam logic [3:0] STEP = 4'(UNROLL);
  localparam logic [3:0] RMAX = 4'(ROUND_MAX);

  type_fsm    fsm_reg, fsm_next;
  type_state  state_reg, state_next;
  logic [3:0] rnd_reg, rnd_next;
  logic       err_reg, err_next;

  logic       n_legal;
  logic [3:0] n_eff;

  type_state  chain [UNROLL+1];

  assign chain[0] = state_reg;

  for (genvar gi = 0; gi < UNROLL; gi++) begin : g_round
    ascon_round u_round (
      .round_idx (rnd_reg + 4'(gi)),
      .x         (chain[gi]),
      .y         (chain[gi+1])
    );
  end

  // Unsupported round counts run the full permutation and are flagged.
  assign n_legal = rounds_legal(nb_rounds_i);
  assign n_eff   = n_legal ? nb_rounds_i : N_ROUNDS_P12;

  always_comb begin
    fsm_next   = fsm_reg;
    state_next = state_reg;
    rnd_next   = rnd_reg;
    err_next   = err_reg;
    case (fsm_reg)
      FSM_BUSY: begin
        if (abort_i) begin
          fsm_next = FSM_IDLE;
        end else begin
          state_next = chain[UNROLL];
          rnd_next   = rnd_reg + STEP;
          if (rnd_reg + STEP == RMAX) begin
            fsm_next = FSM_DONE;
          end
        end
      end
      default: begin
        // IDLE and DONE both accept a start; DONE otherwise falls back to IDLE.
        fsm_next = FSM_IDLE;
        if (start_i) begin
          state_next = state_i;
          rnd_next   = RMAX - n_eff;
          err_next   = ~n_legal;
          fsm_next   = FSM_BUSY;
        end
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_reg   <= FSM_IDLE;
      state_reg <= '0;
      rnd_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      fsm_reg   <= fsm_next;
      state_reg <= state_next;
      rnd_reg   <= rnd_next;
      err_reg   <= err_next;
    end
  end

  assign state_o = state_reg;
  assign ready_o = (fsm_reg != FSM_BUSY);
  assign valid_o = (fsm_reg == FSM_DONE);
  assign err_o   = (fsm_reg == FSM_DONE) && err_reg;

endmodule

// File: tb/tb_ascon_permutation_engine.sv
// Self-checking bench: UNROLL=1 and UNROLL=2 engines against a table-driven ASCON model.
module tb_ascon_permutation_engine;
  import ascon_pack::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_s [2];
  logic [3:0] nb_s    [2];
  logic       abort_s [2];
  type_state  st_in   [2];
  type_state  st_out  [2];
  logic       ready_s [2];
  logic       valid_s [2];
  logic       err_s   [2];

  int n_checks = 0;
  int n_fail   = 0;

  type_state iv_state;

  localparam logic [4:0] SBOX_TAB [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  ascon_permutation_engine #(.UNROLL(1), .ROUND_MAX(12)) dut_u1 (
    .clock_i (clk), .reset_i (rst), .start_i (start_s[0]), .nb_rounds_i (nb_s[0]),
    .abort_i (abort_s[0]), .state_i (st_in[0]), .state_o (st_out[0]),
    .ready_o (ready_s[0]), .valid_o (valid_s[0]), .err_o (err_s[0]));

  ascon_permutation_engine #(.UNROLL(2), .ROUND_MAX(12)) dut_u2 (
    .clock_i (clk), .reset_i (rst), .start_i (start_s[1]), .nb_rounds_i (nb_s[1]),
    .abort_i (abort_s[1]), .state_i (st_in[1]), .state_o (st_out[1]),
    .ready_o (ready_s[1]), .valid_o (valid_s[1]), .err_o (err_s[1]));

  always #5 clk = ~clk;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Rounds first..first+count-1 via the S-box lookup table, column by column.
  function automatic type_state model_rounds(input type_state s, input int first, input int count);
    logic [63:0] w [5];
    logic [63:0] v [5];
    logic [4:0]  col;
    logic [4:0]  sub;
    type_state   res;
    for (int j = 0; j < 5; j++) w[j] = s[j];
    for (int r = first; r < first + count; r++) begin
      w[2] = w[2] ^ 64'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
        col = {w[0][b], w[1][b], w[2][b], w[3][b], w[4][b]};
        sub = SBOX_TAB[col];
        for (int j = 0; j < 5; j++) v[j][b] = sub[4-j];
      end
      w[0] = v[0] ^ rotr(v[0], 19) ^ rotr(v[0], 28);
      w[1] = v[1] ^ rotr(v[1], 61) ^ rotr(v[1], 39);
      w[2] = v[2] ^ rotr(v[2], 1)  ^ rotr(v[2], 6);
      w[3] = v[3] ^ rotr(v[3], 10) ^ rotr(v[3], 17);
      w[4] = v[4] ^ rotr(v[4], 7)  ^ rotr(v[4], 41);
    end
    for (int j = 0; j < 5; j++) res[j] = w[j];
    return res;
  endfunction

  function automatic type_state rand_state();
    type_state s;
    for (int j = 0; j < 5; j++) s[j] = {$urandom(), $urandom()};
    return s;
  endfunction

  // Presents a start for one edge, then scrambles the inputs to prove they were sampled.
  task automatic start_perm(input int i, input type_state s, input logic [3:0] n);
    st_in[i]   = s;
    nb_s[i]    = n;
    start_s[i] = 1'b1;
    @(posedge clk); #1;
    start_s[i] = 1'b0;
    st_in[i]   = rand_state();
    nb_s[i]    = 4'($urandom_range(0, 15));
  endtask

  // lat = number of edges until valid is seen (-1 on timeout); err_early counts err before valid.
  task automatic wait_valid(input int i, input int limit, output int lat, output int err_early);
    lat = -1;
    err_early = 0;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk); #1;
      if (valid_s[i]) begin
        lat = c;
        break;
      end
      if (err_s[i]) err_early++;
    end
  endtask

  task automatic test_reset();
    int bad;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({ready_s[i], valid_s[i], err_s[i]} !== 3'b100 || st_out[i] !== '0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: rdy/vld/err=%b%b%b state=%h, required 100 and zero",
                 i, ready_s[i], valid_s[i], err_s[i], st_out[i]);
      end
    end
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++)
        if (valid_s[i] !== 1'b0 || ready_s[i] !== 1'b1 || st_out[i] !== '0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL idle_quiet: %0d bad idle samples, required 0", bad);
    end
    $display("reset: 3-cycle reset then 20 idle cycles checked");
  endtask

  task automatic test_p12(input int i);
    int u, lat, ee;
    type_state exp;
    u = i + 1;
    start_perm(i, iv_state, N_ROUNDS_P12);
    n_checks++;
    if (st_out[i] !== iv_state || ready_s[i] !== 1'b0) begin
      n_fail++;
      $display("FAIL p12_load dut%0d: state=%h ready=%b, required %h ready 0", i, st_out[i], ready_s[i], iv_state);
    end
    @(posedge clk); #1;
    exp = model_rounds(iv_state, 0, u);
    n_checks++;
    if (st_out[i] !== exp) begin
      n_fail++;
      $display("FAIL p12_first_edge dut%0d: got %h required %h", i, st_out[i], exp);
    end
    wait_valid(i, 40, lat, ee);
    if (lat > 0) lat++;
    exp = model_rounds(iv_state, 0, 12);
    n_checks++;
    if (lat !== 12 / u) begin
      n_fail++;
      $display("FAIL p12_latency dut%0d: got %0d required %0d", i, lat, 12 / u);
    end
    n_checks++;
    if (st_out[i] !== exp || err_s[i] !== 1'b0 || ready_s[i] !== 1'b1 || ee != 0) begin
      n_fail++;
      $display("FAIL p12_result dut%0d: got %h err=%b rdy=%b, required %h err=0 rdy=1", i, st_out[i], err_s[i], ready_s[i], exp);
    end
    @(posedge clk); #1;
    n_checks++;
    if (valid_s[i] !== 1'b0 || ready_s[i] !== 1'b1 || st_out[i] !== exp) begin
      n_fail++;
      $display("FAIL p12_after_done dut%0d: vld=%b rdy=%b state=%h, required 0 1 held", i, valid_s[i], ready_s[i], st_out[i]);
    end
    $display("p12 dut%0d: latency %0d result %h", i, lat, st_out[i]);
  endtask

  task automatic test_short_rounds(input int i);
    int u, lat, ee, n;
    type_state s, exp;
    u = i + 1;
    for (int t = 0; t < 6; t++) begin
      if (t < 2) begin
        s = iv_state;
        n = (t == 0) ? 6 : 8;
      end else begin
        s = rand_state();
        n = (($urandom() % 3) == 0) ? 6 : ((($urandom() % 2) == 0) ? 8 : 12);
      end
      start_perm(i, s, 4'(n));
      // A start while busy must be ignored.
      st_in[i]   = rand_state();
      nb_s[i]    = 4'd6;
      start_s[i] = 1'b1;
      @(posedge clk); #1;
      start_s[i] = 1'b0;
      wait_valid(i, 40, lat, ee);
      if (lat > 0) lat++;
      exp = model_rounds(s, 12 - n, n);
      n_checks++;
      if (lat !== n / u) begin
        n_fail++;
        $display("FAIL short_latency dut%0d p%0d: got %0d required %0d", i, n, lat, n / u);
      end
      n_checks++;
      if (st_out[i] !== exp || err_s[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL short_result dut%0d p%0d: got %h err=%b required %h", i, n, st_out[i], err_s[i], exp);
      end
      $display("p%0d dut%0d: latency %0d result %h", n, i, lat, st_out[i]);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back(input int i);
    int u, lat, ee;
    type_state s1, s2, exp;
    u = i + 1;
    s1 = rand_state();
    s2 = rand_state();
    start_perm(i, s1, N_ROUNDS_P8);
    wait_valid(i, 40, lat, ee);
    exp = model_rounds(s1, 4, 8);
    n_checks++;
    if (lat !== 8 / u || st_out[i] !== exp) begin
      n_fail++;
      $display("FAIL b2b_first dut%0d: lat=%0d state=%h, required lat %0d state %h", i, lat, st_out[i], 8 / u, exp);
    end
    // DONE cycle: next request goes in with no bubble.
    start_perm(i, s2, N_ROUNDS_P6);
    n_checks++;
    if (valid_s[i] !== 1'b0 || ready_s[i] !== 1'b0 || st_out[i] !== s2) begin
      n_fail++;
      $display("FAIL b2b_accept dut%0d: vld=%b rdy=%b state=%h, required 0 0 %h", i, valid_s[i], ready_s[i], st_out[i], s2);
    end
    wait_valid(i, 40, lat, ee);
    if (lat > 0) lat++;
    exp = model_rounds(s2, 6, 6);
    n_checks++;
    if (lat !== 6 / u + 1 || st_out[i] !== exp) begin
      n_fail++;
      $display("FAIL b2b_second dut%0d: lat=%0d state=%h, required lat %0d state %h", i, lat, st_out[i], 6 / u + 1, exp);
    end
    $display("b2b dut%0d: second latency %0d result %h", i, lat, st_out[i]);
    @(posedge clk); #1;
  endtask

  task automatic test_abort(input int i);
    int u, lat, ee, pulses;
    type_state s, exp;
    u = i + 1;
    // Abort in BUSY cycle 5 of p12.
    s = rand_state();
    start_perm(i, s, N_ROUNDS_P12);
    repeat (4) begin @(posedge clk); #1; end
    abort_s[i] = 1'b1;
    @(posedge clk); #1;
    abort_s[i] = 1'b0;
    exp = model_rounds(s, 0, 4 * u);
    n_checks++;
    if (ready_s[i] !== 1'b1 || valid_s[i] !== 1'b0 || st_out[i] !== exp) begin
      n_fail++;
      $display("FAIL abort_mid dut%0d: rdy=%b vld=%b state=%h, required 1 0 %h", i, ready_s[i], valid_s[i], st_out[i], exp);
    end
    pulses = 0;
    repeat (15) begin @(posedge clk); #1; if (valid_s[i] || err_s[i]) pulses++; end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL abort_quiet dut%0d: %0d valid/err samples, required 0", i, pulses);
    end
    // Abort on the final BUSY edge wins over completion.
    s = rand_state();
    start_perm(i, s, N_ROUNDS_P6);
    repeat (6 / u - 1) begin @(posedge clk); #1; end
    abort_s[i] = 1'b1;
    @(posedge clk); #1;
    abort_s[i] = 1'b0;
    exp = model_rounds(s, 6, 6 - u);
    n_checks++;
    if (ready_s[i] !== 1'b1 || valid_s[i] !== 1'b0 || st_out[i] !== exp) begin
      n_fail++;
      $display("FAIL abort_last dut%0d: rdy=%b vld=%b state=%h, required 1 0 %h", i, ready_s[i], valid_s[i], st_out[i], exp);
    end
    // Abort held with start in IDLE has no effect.
    s = rand_state();
    abort_s[i] = 1'b1;
    start_perm(i, s, N_ROUNDS_P8);
    abort_s[i] = 1'b0;
    wait_valid(i, 40, lat, ee);
    exp = model_rounds(s, 4, 8);
    n_checks++;
    if (lat !== 8 / u || st_out[i] !== exp) begin
      n_fail++;
      $display("FAIL abort_idle dut%0d: lat=%0d state=%h, required lat %0d state %h", i, lat, st_out[i], 8 / u, exp);
    end
    $display("abort dut%0d: mid, last-edge and idle cases run", i);
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset(input int i);
    int pulses;
    start_perm(i, rand_state(), N_ROUNDS_P12);
    repeat (2) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (ready_s[i] !== 1'b1 || valid_s[i] !== 1'b0 || err_s[i] !== 1'b0 || st_out[i] !== '0) begin
      n_fail++;
      $display("FAIL async_reset dut%0d: rdy=%b vld=%b err=%b state=%h, required 1 0 0 zero",
               i, ready_s[i], valid_s[i], err_s[i], st_out[i]);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    pulses = 0;
    repeat (15) begin @(posedge clk); #1; if (valid_s[i] || !ready_s[i]) pulses++; end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL reset_quiet dut%0d: %0d bad samples after reset, required 0", i, pulses);
    end
    $display("async reset dut%0d: reset in BUSY cycle 3", i);
  endtask

  task automatic test_illegal(input int i);
    int u, lat, ee;
    type_state exp;
    logic [3:0] bad_n [3];
    bad_n[0] = 4'd7;
    bad_n[1] = 4'd0;
    bad_n[2] = 4'd15;
    u = i + 1;
    exp = model_rounds(iv_state, 0, 12);
    for (int t = 0; t < 3; t++) begin
      start_perm(i, iv_state, bad_n[t]);
      wait_valid(i, 40, lat, ee);
      n_checks++;
      if (lat !== 12 / u || st_out[i] !== exp) begin
        n_fail++;
        $display("FAIL illegal_result dut%0d n=%0d: lat=%0d state=%h, required lat %0d state %h",
                 i, bad_n[t], lat, st_out[i], 12 / u, exp);
      end
      n_checks++;
      if (err_s[i] !== 1'b1 || ee != 0) begin
        n_fail++;
        $display("FAIL illegal_err dut%0d n=%0d: err=%b early=%0d, required err 1 early 0", i, bad_n[t], err_s[i], ee);
      end
      @(posedge clk); #1;
      n_checks++;
      if (err_s[i] !== 1'b0 || valid_s[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_err_pulse dut%0d: err=%b vld=%b after done, required 0 0", i, err_s[i], valid_s[i]);
      end
      $display("illegal n=%0d dut%0d: latency %0d err pulsed", bad_n[t], i, lat);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      nb_s[i]    = 4'd0;
      abort_s[i] = 1'b0;
      st_in[i]   = '0;
    end
    iv_state[0] = 64'h80400c0600000000;
    iv_state[1] = 64'h0001020304050607;
    iv_state[2] = 64'h08090a0b0c0d0e0f;
    iv_state[3] = 64'h0001020304050607;
    iv_state[4] = 64'h08090a0b0c0d0e0f;
    test_reset();
    for (int i = 0; i < 2; i++) test_p12(i);
    for (int i = 0; i < 2; i++) test_short_rounds(i);
    for (int i = 0; i < 2; i++) test_back_to_back(i);
    for (int i = 0; i < 2; i++) test_abort(i);
    for (int i = 0; i < 2; i++) test_async_reset(i);
    for (int i = 0; i < 2; i++) test_illegal(i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
